// File: rtl/debug_sequencer_if.sv
// Host command, PC/phase status and step handshake bundle between host decoder, sequencer and phase decoder.
// The sequencer connects through the slave modport; the host/phase-decoder side uses master.
interface debug_sequencer_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int STEP_WIDTH = 8
);
  logic                  cmd_vld;
  logic                  cmd_rdy;
  logic [2:0]            cmd_op;
  logic [ADDR_WIDTH-1:0] cmd_arg;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  fetch;
  logic                  stopped;
  logic                  debug_stop;
  logic                  debug_mode;
  logic                  debug_step_req;
  logic                  debug_step_ack;
  logic                  halted;
  logic                  bp_hit;
  logic [STEP_WIDTH-1:0] steps_left;
  logic                  cmd_err;

  modport master (
    output cmd_vld, cmd_op, cmd_arg, pc, fetch, stopped, debug_step_ack,
    input  cmd_rdy, debug_stop, debug_mode, debug_step_req, halted, bp_hit, steps_left, cmd_err
  );

  modport slave (
    input  cmd_vld, cmd_op, cmd_arg, pc, fetch, stopped, debug_step_ack,
    output cmd_rdy, debug_stop, debug_mode, debug_step_req, halted, bp_hit, steps_left, cmd_err
  );
endinterface

// File: rtl/debug_sequencer.sv
// Debug sequencer: host halt/run/N-step/debug-exec/breakpoint commands drive the phase decoder DEBUG_* lines.
// Latency: all outputs registered, 1 cycle; backpressure: cmd_rdy low while stopping or stepping.
module debug_sequencer #(
  parameter int ADDR_WIDTH   = 16,
  parameter int STEP_WIDTH   = 8,
  parameter bit RESET_HALTED = 1'b0
) (
  input logic              clk,
  input logic              rst,
  debug_sequencer_if.slave dbg
);

  typedef enum logic [2:0] {
    OP_NOP, OP_HALT, OP_RUN, OP_STEP, OP_EXEC, OP_SET_BP, OP_CLR_BP, OP_RSVD
  } op_e;

  typedef enum logic [2:0] {
    S_RUN, S_STOPPING, S_HALT, S_STEP_REQ, S_STEP_REL
  } state_e;

  localparam state_e RESET_STATE = RESET_HALTED ? S_STOPPING : S_RUN;

  state_e                state_q, state_n;
  logic                  stop_q, stop_n;
  logic                  mode_q, mode_n;
  logic                  req_q, req_n;
  logic                  halted_q, halted_n;
  logic                  bp_hit_q, bp_hit_n;
  logic                  bp_en_q, bp_en_n;
  logic                  err_q, err_n;
  logic                  rdy_q, rdy_n;
  logic [ADDR_WIDTH-1:0] bp_addr_q, bp_addr_n;
  logic [STEP_WIDTH-1:0] steps_q, steps_n;
  logic [STEP_WIDTH-1:0] step_arg;
  logic                  accept;
  logic                  bp_match;
  op_e                   op;

  assign op       = op_e'(dbg.cmd_op);
  assign accept   = dbg.cmd_vld && rdy_q;
  assign step_arg = dbg.cmd_arg[STEP_WIDTH-1:0];
  assign bp_match = bp_en_q && dbg.fetch && (dbg.pc == bp_addr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RESET_STATE;
      stop_q    <= RESET_HALTED;
      mode_q    <= 1'b0;
      req_q     <= 1'b0;
      halted_q  <= 1'b0;
      bp_hit_q  <= 1'b0;
      bp_en_q   <= 1'b0;
      bp_addr_q <= '0;
      steps_q   <= '0;
      err_q     <= 1'b0;
      rdy_q     <= !RESET_HALTED;
    end else begin
      state_q   <= state_n;
      stop_q    <= stop_n;
      mode_q    <= mode_n;
      req_q     <= req_n;
      halted_q  <= halted_n;
      bp_hit_q  <= bp_hit_n;
      bp_en_q   <= bp_en_n;
      bp_addr_q <= bp_addr_n;
      steps_q   <= steps_n;
      err_q     <= err_n;
      rdy_q     <= rdy_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    stop_n    = stop_q;
    mode_n    = mode_q;
    req_n     = req_q;
    halted_n  = halted_q;
    bp_hit_n  = bp_hit_q;
    bp_en_n   = bp_en_q;
    bp_addr_n = bp_addr_q;
    steps_n   = steps_q;
    err_n     = 1'b0;

    unique case (state_q)
      S_RUN: begin
        stop_n = 1'b0;
        if (accept) begin
          case (op)
            OP_HALT: begin
              stop_n  = 1'b1;
              state_n = S_STOPPING;
            end
            OP_SET_BP: begin
              bp_addr_n = dbg.cmd_arg;
              bp_en_n   = 1'b1;
              bp_hit_n  = 1'b0;
            end
            OP_CLR_BP: begin
              bp_en_n  = 1'b0;
              bp_hit_n = 1'b0;
            end
            OP_STEP, OP_EXEC, OP_RSVD: err_n = 1'b1;
            default: ;
          endcase
        end
        // Breakpoint compare uses the pre-command bp registers and wins over a same-cycle clear.
        if (bp_match) begin
          bp_hit_n = 1'b1;
          stop_n   = 1'b1;
          state_n  = S_STOPPING;
        end
      end

      S_STOPPING: begin
        if (dbg.stopped) begin
          halted_n = 1'b1;
          state_n  = S_HALT;
        end
      end

      S_HALT: begin
        if (accept) begin
          case (op)
            OP_RUN: begin
              stop_n   = 1'b0;
              halted_n = 1'b0;
              state_n  = S_RUN;
            end
            OP_STEP: begin
              steps_n  = (step_arg == '0) ? STEP_WIDTH'(1) : step_arg;
              mode_n   = 1'b0;
              req_n    = 1'b1;
              halted_n = 1'b0;
              state_n  = S_STEP_REQ;
            end
            OP_EXEC: begin
              steps_n  = STEP_WIDTH'(1);
              mode_n   = 1'b1;
              req_n    = 1'b1;
              halted_n = 1'b0;
              state_n  = S_STEP_REQ;
            end
            OP_SET_BP: begin
              bp_addr_n = dbg.cmd_arg;
              bp_en_n   = 1'b1;
              bp_hit_n  = 1'b0;
            end
            OP_CLR_BP: begin
              bp_en_n  = 1'b0;
              bp_hit_n = 1'b0;
            end
            OP_RSVD: err_n = 1'b1;
            default: ;
          endcase
        end
      end

      S_STEP_REQ: begin
        if (dbg.debug_step_ack) begin
          req_n   = 1'b0;
          steps_n = (steps_q == '0) ? '0 : steps_q - STEP_WIDTH'(1);
          state_n = S_STEP_REL;
        end
      end

      S_STEP_REL: begin
        // REQ may only rise again once the phase decoder has dropped ACK.
        if (!dbg.debug_step_ack) begin
          if (steps_q != '0) begin
            req_n   = 1'b1;
            state_n = S_STEP_REQ;
          end else begin
            mode_n   = 1'b0;
            halted_n = 1'b1;
            state_n  = S_HALT;
          end
        end
      end

      default: state_n = RESET_STATE;
    endcase

    rdy_n = (state_n == S_RUN) || (state_n == S_HALT);
  end

  assign dbg.cmd_rdy        = rdy_q;
  assign dbg.debug_stop     = stop_q;
  assign dbg.debug_mode     = mode_q;
  assign dbg.debug_step_req = req_q;
  assign dbg.halted         = halted_q;
  assign dbg.bp_hit         = bp_hit_q;
  assign dbg.steps_left     = steps_q;
  assign dbg.cmd_err        = err_q;

endmodule
